// File: rtl/perf_dump_pkg.sv
// Shared definitions for the performance-counter dump block.
// Holds the dump FSM state encoding, the frame geometry and the default
// frame header byte.
package perf_dump_pkg;

    // Dump FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    // Header + 12 payload bytes + checksum
    localparam int FRAME_LEN   = 14;
    localparam int PAYLOAD_LEN = 12;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage : perf_dump_pkg

// File: rtl/perf_counter_dumper.sv
// perf_counter_dumper
// Freezes the four performance counters on a rising edge of finish and
// streams them as a 14-byte frame over a valid/ready byte interface:
// HEADER, four counters as 3 little-endian bytes each, then an 8-bit sum
// of the 12 payload bytes.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   finish            program-finished level from the core
//   instruction_count instruction counter value
//   aritmetric_count  arithmetic counter value
//   memory_count      memory-access counter value
//   stall_count       stall counter value
//   tx_data           byte offered to the transmitter (registered)
//   tx_valid          tx_data is valid (registered)
//   tx_ready          transmitter accepts the byte this cycle
//   busy              frame in progress (registered)
//   done              frame complete, held until finish drops (registered)
module perf_counter_dumper
    import perf_dump_pkg::*;
#(
    parameter int         COUNT_W = 19,
    parameter logic [7:0] HEADER  = DEFAULT_HEADER
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               finish,
    input  logic [COUNT_W-1:0] instruction_count,
    input  logic [COUNT_W-1:0] aritmetric_count,
    input  logic [COUNT_W-1:0] memory_count,
    input  logic [COUNT_W-1:0] stall_count,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_LEN);

    dump_state_t       state_r, state_s;
    logic [3:0][23:0]  snap_r, snap_s;
    logic [7:0]        csum_r, csum_s;
    logic [3:0]        idx_r, idx_s;
    logic              finish_q_r;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              tx_valid_r, tx_valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    logic              trigger_s;
    logic              accept_s;
    logic [3:0]        idx_inc_s;
    logic [7:0]        next_byte_s;

    assign trigger_s = finish & ~finish_q_r;
    assign accept_s  = tx_valid_r & tx_ready;
    assign idx_inc_s = idx_r + 4'd1;

    // Payload byte mux: index 1..12 selects snapshot bytes, LSB first
    always_comb begin
        next_byte_s = 8'h00;
        case (idx_inc_s)
            4'd1:    next_byte_s = snap_r[0][7:0];
            4'd2:    next_byte_s = snap_r[0][15:8];
            4'd3:    next_byte_s = snap_r[0][23:16];
            4'd4:    next_byte_s = snap_r[1][7:0];
            4'd5:    next_byte_s = snap_r[1][15:8];
            4'd6:    next_byte_s = snap_r[1][23:16];
            4'd7:    next_byte_s = snap_r[2][7:0];
            4'd8:    next_byte_s = snap_r[2][15:8];
            4'd9:    next_byte_s = snap_r[2][23:16];
            4'd10:   next_byte_s = snap_r[3][7:0];
            4'd11:   next_byte_s = snap_r[3][15:8];
            4'd12:   next_byte_s = snap_r[3][23:16];
            default: next_byte_s = 8'h00;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) state_s = ST_SEND;
                else           state_s = ST_IDLE;
            end
            ST_SEND: begin
                if (accept_s && (idx_r == LAST_IDX)) state_s = ST_CSUM;
                else                                 state_s = ST_SEND;
            end
            ST_CSUM: begin
                if (accept_s) state_s = ST_DONE;
                else          state_s = ST_CSUM;
            end
            ST_DONE: begin
                if (!finish) state_s = ST_IDLE;
                else         state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        snap_s     = snap_r;
        csum_s     = csum_r;
        idx_s      = idx_r;
        tx_data_s  = tx_data_r;
        tx_valid_s = tx_valid_r;
        busy_s     = busy_r;
        done_s     = done_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    snap_s[0]  = 24'(instruction_count);
                    snap_s[1]  = 24'(aritmetric_count);
                    snap_s[2]  = 24'(memory_count);
                    snap_s[3]  = 24'(stall_count);
                    csum_s     = 8'h00;
                    idx_s      = 4'd0;
                    tx_data_s  = HEADER;
                    tx_valid_s = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    tx_valid_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (accept_s) begin
                    idx_s = idx_inc_s;
                    // tx_data_r is the byte just accepted; the header (idx 0)
                    // is not part of the sum
                    if (idx_r != 4'd0) begin
                        csum_s = csum_r + tx_data_r;
                    end else begin
                        csum_s = csum_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        tx_data_s = csum_r + tx_data_r;
                    end else begin
                        tx_data_s = next_byte_s;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    tx_valid_s = 1'b0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                end else begin
                    tx_valid_s = 1'b1;
                end
            end
            ST_DONE: begin
                if (!finish) done_s = 1'b0;
                else         done_s = 1'b1;
            end
            default: begin
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
                done_s     = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            snap_r     <= {4{24'h000000}};
            csum_r     <= 8'h00;
            idx_r      <= 4'd0;
            finish_q_r <= 1'b1;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            snap_r     <= snap_s;
            csum_r     <= csum_s;
            idx_r      <= idx_s;
            finish_q_r <= finish;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule : perf_counter_dumper

// File: tb/tb_perf_counter_dumper.sv
// Directed self-checking bench for perf_counter_dumper.
module tb_perf_counter_dumper;

    localparam int CW = 19;

    logic          clk;
    logic          rst;
    logic          finish;
    logic [CW-1:0] instruction_count;
    logic [CW-1:0] aritmetric_count;
    logic [CW-1:0] memory_count;
    logic [CW-1:0] stall_count;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_basic [14] = '{8'hA5, 8'hFF, 8'hFF, 8'h07, 8'h05, 8'h00, 8'h00,
                                   8'h03, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h0F};
    logic [7:0] exp_zero  [14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_wrap  [14] = '{8'hA5, 8'hFF, 8'hFF, 8'h07, 8'hFF, 8'hFF, 8'h07,
                                   8'hFF, 8'hFF, 8'h07, 8'hFF, 8'hFF, 8'h07, 8'h14};

    perf_counter_dumper #(.COUNT_W(CW), .HEADER(8'hA5)) dut (
        .clk               (clk),
        .rst               (rst),
        .finish            (finish),
        .instruction_count (instruction_count),
        .aritmetric_count  (aritmetric_count),
        .memory_count      (memory_count),
        .stall_count       (stall_count),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .tx_valid          (tx_valid),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_counters(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                input logic [CW-1:0] c, input logic [CW-1:0] d);
        instruction_count = a;
        aritmetric_count  = b;
        memory_count      = c;
        stall_count       = d;
    endtask

    // Drop finish, then raise it; the caller follows with run_frame.
    task automatic retrigger();
        @(negedge clk);
        finish = 1'b0;
        @(negedge clk);
        check_eq("done_clear", done, 1'b0);
        finish = 1'b1;
    endtask

    // Collect one frame. bp selects ready pattern 1,0,0,...; zero_after_hdr
    // clears counter inputs once the header is accepted.
    task automatic run_frame(input string tag, input logic [7:0] exp [14],
                             input bit bp, input bit zero_after_hdr);
        int         n = 0;
        int         cyc = 0;
        int         first_cyc = 0;
        int         last_cyc = 0;
        logic       pend = 1'b0;
        logic [7:0] pd = 8'h00;
        while (n < 14 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq({tag, "_latency"}, tx_valid, 1'b1);
            if (pend) begin
                check_eq({tag, "_hold_valid"}, tx_valid, 1'b1);
                check_eq({tag, "_hold_data"}, tx_data, pd);
            end
            tx_ready = bp ? (((cyc - 1) % 3) == 0) : 1'b1;
            if (tx_valid && tx_ready) begin
                check_eq($sformatf("%s_b%0d", tag, n), tx_data, exp[n]);
                check_eq($sformatf("%s_busy%0d", tag, n), busy, 1'b1);
                if (n == 0) first_cyc = cyc;
                last_cyc = cyc;
                n++;
                pend = 1'b0;
                if (zero_after_hdr && n == 1) set_counters('0, '0, '0, '0);
            end else begin
                pend = tx_valid;
            end
            pd = tx_data;
        end
        tx_ready = 1'b1;
        check_eq({tag, "_nbytes"}, n, 14);
        if (!bp) check_eq({tag, "_span"}, last_cyc - first_cyc, 13);
        @(negedge clk);
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_busy_end"}, busy, 1'b0);
        check_eq({tag, "_valid_end"}, tx_valid, 1'b0);
    endtask

    initial begin
        rst      = 1'b0;
        finish   = 1'b1;
        tx_ready = 1'b1;
        set_counters('0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check_eq("rst_data", tx_data, 8'h00);
        check_eq("rst_valid", tx_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        rst = 1'b1;

        // finish held high through reset must not trigger
        repeat (4) begin
            @(negedge clk);
            check_eq("no_trig_after_rst", tx_valid, 1'b0);
        end

        // Basic dump
        set_counters(19'h7FFFF, 19'd5, 19'd3, 19'd2);
        retrigger();
        run_frame("basic", exp_basic, 1'b0, 1'b0);

        // finish held high after done: no second frame
        repeat (10) begin
            @(negedge clk);
            check_eq("hold_no_frame", tx_valid, 1'b0);
            check_eq("hold_done", done, 1'b1);
        end

        // Backpressure
        retrigger();
        run_frame("bp", exp_basic, 1'b1, 1'b0);

        // Snapshot hold
        retrigger();
        run_frame("snap", exp_basic, 1'b0, 1'b1);

        // Retrigger with all counters zero
        set_counters('0, '0, '0, '0);
        retrigger();
        run_frame("zero", exp_zero, 1'b0, 1'b0);

        // Checksum wrap
        set_counters(19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF);
        retrigger();
        run_frame("wrap", exp_wrap, 1'b0, 1'b0);

        // Reset mid-frame after five bytes accepted
        set_counters(19'h7FFFF, 19'd5, 19'd3, 19'd2);
        retrigger();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", tx_valid, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("midrst_no_frame", tx_valid, 1'b0);
        end
        retrigger();
        run_frame("after_rst", exp_basic, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_perf_counter_dumper
